// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg : shared AES S-box tables, engine FSM state type, LANES legality check
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Element 0 is the leftmost byte of each table.
  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic bit lanes_legal(int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// aes_sbox : combinational forward / inverse AES S-box lookup
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in,
  input  logic       inv,
  output logic [7:0] out
);

  assign out = inv ? SBOX_INV[in] : SBOX_FWD[in];

endmodule

`default_nettype wire

// File: rtl/aes_sub_bytes_seq.sv
// ============================================================================
// aes_sub_bytes_seq : sequential SubBytes/InvSubBytes engine, LANES bytes/cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] block,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] new_block,
  output logic         busy
);

  localparam int NBEATS = 16 / LANES;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CW-1:0] C_LAST_BEAT = CW'(NBEATS - 1);

  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    work_q, work_d;
  logic            mode_q, mode_d;

  logic [LANES-1:0][7:0] w_lane_in;
  logic [LANES-1:0][7:0] w_lane_out;

  // Byte 0 sits in the top bits, so beat cnt covers bytes cnt*LANES onward.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_lane_in[l] = work_q[8*(15 - (int'(cnt_q)*LANES + l)) +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .in  (w_lane_in[g]),
      .inv (mode_q),
      .out (w_lane_out[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    mode_d    = mode_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = block;
          mode_d  = inv;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          work_d[8*(15 - (int'(cnt_q)*LANES + l)) +: 8] = w_lane_out[l];
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_BEAT) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d  = block;
            mode_d  = inv;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
    end
  end

  assign new_block = work_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_sub_bytes_seq.sv
// ============================================================================
// tb_aes_sub_bytes_seq : scoreboard bench, S-box model built from GF(2^8) math
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aes_sub_bytes_seq;

  localparam logic [127:0] C_FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] C_FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] block;
  logic         inv;
  logic         out_ready;

  logic         in_rdy [5];
  logic         ov     [5];
  logic         bsy    [5];
  logic         ordy   [5];
  logic [127:0] nb     [5];

  always #5 clk = ~clk;

  // Instance g runs LANES = 1<<g; instance 2 (LANES=4) is the main DUT.
  for (genvar g = 0; g < 5; g++) begin : g_dut
    if (g == 2) begin : g_main_rdy
      assign ordy[g] = out_ready;
    end else begin : g_tied_rdy
      assign ordy[g] = 1'b1;
    end
    aes_sub_bytes_seq #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_rdy[g]),
      .block     (block),
      .inv       (inv),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .new_block (nb[g]),
      .busy      (bsy[g])
    );
  end

  int           n_cmp = 0;
  int           n_err = 0;
  logic [7:0]   ftab [256];
  logic [7:0]   itab [256];
  logic [127:0] sb_q [$];

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_math(logic [7:0] a);
    logic [7:0] x = 8'h01;
    for (int i = 0; i < 254; i++) x = gmul(x, a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(logic [127:0] blk, logic iv);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) begin
      r[127-8*b -: 8] = iv ? itab[blk[127-8*b -: 8]] : ftab[blk[127-8*b -: 8]];
    end
    return r;
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic accept(logic [127:0] blk, logic iv);
    int n = 0;
    block    = blk;
    inv      = iv;
    in_valid = 1'b1;
    while (!in_rdy[2] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy[2]) check("accept_timeout", {127'd0, in_rdy[2]}, 128'd1);
    sb_q.push_back(model(blk, iv));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    block    = {$urandom, $urandom, $urandom, $urandom};
    inv      = 1'($urandom);
  endtask

  task automatic wait_out(string tag, int exp_lat);
    int lat = 0;
    logic [127:0] exp;
    while (!ov[2] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 128'hx;
    if (!ov[2]) begin
      check({tag, "_timeout"}, {127'd0, ov[2]}, 128'd1);
    end else begin
      check(tag, nb[2], exp);
      check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    end
  endtask

  initial begin
    int           lat [5];
    logic [127:0] got [5];
    logic [127:0] exp_a;
    int           seen;

    for (int v = 0; v < 256; v++) ftab[v] = sbox_math(8'(v));
    for (int v = 0; v < 256; v++) itab[ftab[v]] = 8'(v);

    rst_n = 1'b0; in_valid = 1'b0; block = '0; inv = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {127'd0, in_rdy[2]}, 128'd1);
    check("rst_out_valid", {127'd0, ov[2]},     128'd0);
    check("rst_busy",      {127'd0, bsy[2]},    128'd0);
    check("rst_new_block", nb[2],               128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 vector through all five lane widths at once.
    for (int i = 0; i < 5; i++) lat[i] = -1;
    accept(C_FIPS_IN, 1'b0);
    check("busy_in_run", {127'd0, bsy[2]}, 128'd1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        if (ov[i] && lat[i] < 0) begin
          lat[i] = k;
          got[i] = nb[i];
        end
      end
    end
    exp_a = sb_q.pop_front();
    check("fips_sb_main", got[2], exp_a);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fips_lanes%0d", 1 << i), got[i], C_FIPS_OUT);
      check($sformatf("lat_lanes%0d", 1 << i), 128'(lat[i]), 128'(16 >> i));
    end

    // Directed vectors; successive blocks chain DONE->RUN.
    accept(C_FIPS_OUT, 1'b1);                wait_out("fips_inverse", 4);
    accept(128'h0, 1'b0);                    wait_out("all00_fwd", 4);
    accept({16{8'hff}}, 1'b0);               wait_out("allff_fwd", 4);
    accept({16{8'h63}}, 1'b1);               wait_out("all63_inv", 4);
    accept(128'h00112233445566778899aabbccddeeff, 1'b0); wait_out("seq_fwd", 4);
    accept(128'hf0e1d2c3b4a5968778695a4b3c2d1e0f, 1'b1); wait_out("seq_inv", 4);

    // Backpressure: hold the result, then chain a new block on release.
    @(negedge clk);
    out_ready = 1'b0;
    accept(128'h0123456789abcdeffedcba9876543210, 1'b0);
    exp_a = model(128'h0123456789abcdeffedcba9876543210, 1'b0);
    wait_out("bp_first", 4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_stable",    nb[2],               exp_a);
      check("bp_in_ready",  {127'd0, in_rdy[2]}, 128'd0);
      check("bp_out_valid", {127'd0, ov[2]},     128'd1);
    end
    block     = 128'hdeadbeefcafef00d0badc0de12345678;
    inv       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_comb", {127'd0, in_rdy[2]}, 128'd1);
    sb_q.push_back(model(128'hdeadbeefcafef00d0badc0de12345678, 1'b0));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_chain_busy", {127'd0, bsy[2]}, 128'd1);
    wait_out("bp_chained", 4);

    // Reset in the middle of RUN discards the block.
    @(negedge clk);
    accept(128'h3243f6a8885a308d313198a2e0370734, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  {127'd0, in_rdy[2]}, 128'd1);
    check("mid_rst_out_valid", {127'd0, ov[2]},     128'd0);
    check("mid_rst_busy",      {127'd0, bsy[2]},    128'd0);
    check("mid_rst_new_block", nb[2],               128'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov[2]) seen++;
    end
    check("mid_rst_no_output", 128'(seen), 128'd0);
    accept(C_FIPS_IN, 1'b0);
    wait_out("post_rst_fips", 4);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
